// File: rtl/riscv_exc_arbiter_if.sv
// Trap handshake between the exception arbiter and the core controller.
// Handshake: the arbiter raises exc_req_o with a stable exc_cause_o; the
// controller accepts by asserting exc_ack_i while exc_req_o is high (ack at
// any other time is ignored). One cycle after the accepting cycle the arbiter
// drops exc_req_o and pulses save_exc_cause_o for exactly one cycle so the CSR
// block latches exc_cause_o. An interrupt request may be withdrawn (exc_req_o
// falls without a save strobe) if its line or the global enable goes away
// before an ack; synchronous exception requests are never withdrawn.
interface riscv_exc_arbiter_if;
  logic       exc_req_o;
  logic       exc_ack_i;
  logic [5:0] exc_cause_o;
  logic       save_exc_cause_o;

  // Arbiter side
  modport master (
    output exc_req_o,
    output exc_cause_o,
    output save_exc_cause_o,
    input  exc_ack_i
  );

  // Controller / CSR side
  modport slave (
    input  exc_req_o,
    input  exc_cause_o,
    input  save_exc_cause_o,
    output exc_ack_i
  );
endinterface

// File: rtl/riscv_exc_arbiter.sv
// Trap arbitration stage in front of the CSR block: collects interrupts,
// decoder exceptions and DIFT tag violations, selects one cause by fixed
// priority, handshakes it with the controller and emits a save strobe.
// Also keeps a saturating DIFT violation counter for software.
module riscv_exc_arbiter #(
  parameter int N_IRQ      = 32,
  parameter int VIOL_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IRQ-1:0]      irq_i,
  input  logic                  irq_enable_i,
  input  logic                  illegal_insn_i,
  input  logic                  ebreak_insn_i,
  input  logic                  ecall_insn_i,
  input  logic                  tag_viol_i,
  input  logic [2:0]            tag_viol_src_i,
  input  logic                  tag_trap_en_i,
  riscv_exc_arbiter_if.master   exc_if,
  output logic [VIOL_CNT_W-1:0] viol_cnt_o,
  output logic [2:0]            viol_src_o,
  input  logic                  viol_cnt_clr_i,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SAVE = 2'd2
  } state_t;

  localparam logic [5:0] CAUSE_ILLEGAL = 6'h02;
  localparam logic [5:0] CAUSE_EBREAK  = 6'h03;
  localparam logic [5:0] CAUSE_ECALL   = 6'h0B;

  state_t                state_q;
  logic                  req_q;
  logic                  save_q;
  logic [5:0]            cause_q;
  logic [N_IRQ-1:0]      irq_q;
  logic [VIOL_CNT_W-1:0] viol_cnt_q;
  logic [2:0]            viol_src_q;

  logic [31:0]           irq_ext;
  logic                  irq_hit;
  logic [4:0]            irq_idx;
  logic                  cand_valid;
  logic [5:0]            cand_cause;
  logic                  irq_gone;

  // Register the interrupt lines; arbitration only ever looks at irq_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= '0;
    end else begin
      irq_q <= irq_i;
    end
  end

  // Fixed-priority candidate selection and interrupt-withdraw detection
  always_comb begin
    irq_ext = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      irq_ext[i] = irq_q[i];
    end

    // Scan downwards so the lowest active index is the one left standing
    irq_hit = 1'b0;
    irq_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (irq_ext[i]) begin
        irq_hit = 1'b1;
        irq_idx = i[4:0];
      end
    end

    cand_valid = 1'b1;
    cand_cause = '0;
    if (illegal_insn_i) begin
      cand_cause = CAUSE_ILLEGAL;
    end else if (ebreak_insn_i) begin
      cand_cause = CAUSE_EBREAK;
    end else if (ecall_insn_i) begin
      cand_cause = CAUSE_ECALL;
    end else if (tag_viol_i && tag_trap_en_i) begin
      cand_cause = {3'b010, tag_viol_src_i};
    end else if (irq_hit && irq_enable_i) begin
      cand_cause = {1'b1, irq_idx};
    end else begin
      cand_valid = 1'b0;
    end

    // Only interrupt causes can disappear under a pending request
    irq_gone = cause_q[5] && (!irq_ext[cause_q[4:0]] || !irq_enable_i);
  end

  // Trap handshake FSM with registered request, strobe and cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      save_q  <= 1'b0;
      cause_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          save_q <= 1'b0;
          if (cand_valid) begin
            cause_q <= cand_cause;
            req_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Ack beats a simultaneous withdraw
          if (exc_if.exc_ack_i) begin
            req_q   <= 1'b0;
            save_q  <= 1'b1;
            state_q <= ST_SAVE;
          end else if (irq_gone) begin
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_SAVE: begin
          save_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          save_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating violation counter; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      viol_cnt_q <= '0;
      viol_src_q <= '0;
    end else begin
      if (viol_cnt_clr_i) begin
        viol_cnt_q <= '0;
      end else if (tag_viol_i && (viol_cnt_q != {VIOL_CNT_W{1'b1}})) begin
        viol_cnt_q <= viol_cnt_q + 1'b1;
      end
      if (tag_viol_i) begin
        viol_src_q <= tag_viol_src_i;
      end
    end
  end

  assign exc_if.exc_req_o        = req_q;
  assign exc_if.save_exc_cause_o = save_q;
  assign exc_if.exc_cause_o      = cause_q;
  assign viol_cnt_o              = viol_cnt_q;
  assign viol_src_o              = viol_src_q;
  assign dbg_state_o             = state_q;

endmodule

// File: tb/tb_riscv_exc_arbiter.sv
// Bench for riscv_exc_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a trap-level reference model.
module tb_riscv_exc_arbiter;
  localparam int N_IRQ = 32;
  localparam int CW    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N_IRQ-1:0] irq;
  logic             irq_en;
  logic             ill, ebr, ecl;
  logic             tag;
  logic [2:0]       tag_src;
  logic             trap_en;
  logic             ack;
  logic             clr;
  logic [CW-1:0]    viol_cnt;
  logic [2:0]       viol_src;
  logic [1:0]       dbg_state;

  riscv_exc_arbiter_if exc_if ();
  assign exc_if.exc_ack_i = ack;

  riscv_exc_arbiter #(.N_IRQ(N_IRQ), .VIOL_CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .irq_i          (irq),
    .irq_enable_i   (irq_en),
    .illegal_insn_i (ill),
    .ebreak_insn_i  (ebr),
    .ecall_insn_i   (ecl),
    .tag_viol_i     (tag),
    .tag_viol_src_i (tag_src),
    .tag_trap_en_i  (trap_en),
    .exc_if         (exc_if),
    .viol_cnt_o     (viol_cnt),
    .viol_src_o     (viol_src),
    .viol_cnt_clr_i (clr),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks what the outside world should see: is a trap being requested,
  // is a save strobe due, which cause is on offer, plus the counter.
  logic          m_req, m_save;
  logic [5:0]    m_cause;
  logic [CW-1:0] m_cnt;
  logic [2:0]    m_src;
  logic [31:0]   m_irq_seen;   // interrupt lines as seen one cycle late

  task automatic model_reset();
    m_req = 0; m_save = 0; m_cause = 0; m_cnt = 0; m_src = 0; m_irq_seen = 0;
    exp_q.delete();
  endtask

  task automatic model_tick();
    logic       hit;
    logic [5:0] pick;
    hit = 0; pick = 0;
    if (m_save) begin
      m_save = 0;                              // strobe done, nothing arbitrated
    end else if (m_req) begin
      if (ack) begin
        m_req = 0; m_save = 1;
        exp_q.push_back(m_cause);
      end else if (m_cause[5] && (!m_irq_seen[m_cause[4:0]] || !irq_en)) begin
        m_req = 0;
      end
    end else begin
      if (ill)                 begin hit = 1; pick = 6'h02; end
      else if (ebr)            begin hit = 1; pick = 6'h03; end
      else if (ecl)            begin hit = 1; pick = 6'h0B; end
      else if (tag && trap_en) begin hit = 1; pick = 6'h10 + 6'(tag_src); end
      else if (irq_en) begin
        for (int k = 0; k < N_IRQ; k++)
          if (!hit && m_irq_seen[k]) begin hit = 1; pick = 6'd32 + 6'(k); end
      end
      if (hit) begin m_req = 1; m_cause = pick; end
    end
    if (clr)                           m_cnt = 0;
    else if (tag && m_cnt != CW'(15))  m_cnt = m_cnt + 1;
    if (tag) m_src = tag_src;
    m_irq_seen = 32'(irq);
  endtask

  task automatic check_outputs();
    check("req",   32'(exc_if.exc_req_o),        32'(m_req));
    check("save",  32'(exc_if.save_exc_cause_o), 32'(m_save));
    check("cause", 32'(exc_if.exc_cause_o),      32'(m_cause));
    check("cnt",   32'(viol_cnt),                32'(m_cnt));
    check("src",   32'(viol_src),                32'(m_src));
    if (exc_if.save_exc_cause_o) begin
      if (exp_q.size() > 0) check("saved_cause", 32'(exc_if.exc_cause_o), 32'(exp_q.pop_front()));
      else                  check("save_spurious", 32'(1), 32'(0));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic quiet();
    ill = 0; ebr = 0; ecl = 0; tag = 0; ack = 0; clr = 0;
  endtask

  // One clock: DUT and model both consume the inputs set before this call
  task automatic cycle();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    quiet();
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst_n = 0;
    quiet();
    irq = 0; irq_en = 0; trap_en = 0; tag_src = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    quiet();
    irq = 0; irq_en = 0; trap_en = 0; tag_src = 0;
    rst_n = 0;
    #1;
    do_reset();

    // Reset values
    check("rst_req",   32'(exc_if.exc_req_o),        0);
    check("rst_save",  32'(exc_if.save_exc_cause_o), 0);
    check("rst_cause", 32'(exc_if.exc_cause_o),      0);
    check("rst_cnt",   32'(viol_cnt),                0);
    check("rst_src",   32'(viol_src),                0);

    // ecall at t, ack at t+3
    ecl = 1; cycle(); ecl = 0;
    check("ecall_req_t1", 32'(exc_if.exc_req_o), 1);
    check("ecall_cause",  32'(exc_if.exc_cause_o), 32'h0B);
    cycle(); cycle();
    check("ecall_req_t3", 32'(exc_if.exc_req_o), 1);
    ack = 1; cycle(); ack = 0;
    check("ecall_save_t4", 32'(exc_if.save_exc_cause_o), 1);
    check("ecall_req_t4",  32'(exc_if.exc_req_o), 0);
    cycle();
    check("ecall_save_t5", 32'(exc_if.save_exc_cause_o), 0);
    check("ecall_cause_hold", 32'(exc_if.exc_cause_o), 32'h0B);
    idle_cycles(2);

    // irq 5 and 2 together, lowest index wins, request two cycles after rise
    irq_en = 1; irq[5] = 1; irq[2] = 1;
    cycle();
    check("irq_req_t1", 32'(exc_if.exc_req_o), 0);
    cycle();
    check("irq_req_t2", 32'(exc_if.exc_req_o), 1);
    check("irq_cause",  32'(exc_if.exc_cause_o), 32'h22);
    cycle();
    ack = 1; irq = 0; cycle(); ack = 0;
    check("irq_save", 32'(exc_if.save_exc_cause_o), 1);
    idle_cycles(3);

    // illegal beats a same-cycle trapping tag violation
    trap_en = 1; ill = 1; tag = 1; tag_src = 3'd3;
    cycle(); quiet();
    check("ill_cause", 32'(exc_if.exc_cause_o), 32'h02);
    check("ill_cnt",   32'(viol_cnt), 1);
    check("ill_src",   32'(viol_src), 3);
    ack = 1; cycle(); idle_cycles(2);
    trap_en = 0;

    // irq 7 withdrawn by dropping the enable
    irq_en = 1; irq[7] = 1;
    cycle(); cycle();
    check("wd_req", 32'(exc_if.exc_req_o), 1);
    check("wd_cause", 32'(exc_if.exc_cause_o), 32'h27);
    irq_en = 0; cycle();
    check("wd_req_drop", 32'(exc_if.exc_req_o), 0);
    check("wd_no_save",  32'(exc_if.save_exc_cause_o), 0);
    cycle();
    check("wd_no_save2", 32'(exc_if.save_exc_cause_o), 0);
    // Same again, with ack in the drop cycle: ack wins
    irq_en = 1; cycle();
    check("wd2_req", 32'(exc_if.exc_req_o), 1);
    cycle();
    irq_en = 0; ack = 1; cycle(); ack = 0;
    check("wd2_save",  32'(exc_if.save_exc_cause_o), 1);
    check("wd2_cause", 32'(exc_if.exc_cause_o), 32'h27);
    irq = 0; irq_en = 1;
    idle_cycles(3);

    // Counter saturation without trapping, then clear against a pulse
    trap_en = 0; clr = 1; cycle(); clr = 0;
    for (int i = 0; i < 20; i++) begin
      tag = 1; tag_src = 3'($urandom_range(0, 7));
      cycle();
    end
    quiet();
    check("sat_cnt", 32'(viol_cnt), 32'hF);
    check("sat_no_req", 32'(exc_if.exc_req_o), 0);
    tag = 1; clr = 1; cycle(); quiet();
    check("clr_cnt", 32'(viol_cnt), 0);

    // Asynchronous reset while a request is pending
    ebr = 1; cycle(); quiet();
    check("rst_mid_req", 32'(exc_if.exc_req_o), 1);
    #2 rst_n = 0;
    #1;
    check("arst_req",   32'(exc_if.exc_req_o), 0);
    check("arst_cause", 32'(exc_if.exc_cause_o), 0);
    check("arst_cnt",   32'(viol_cnt), 0);
    do_reset();
    irq_en = 1;
    ebr = 1; cycle(); quiet();
    check("post_rst_cause", 32'(exc_if.exc_cause_o), 32'h03);
    ack = 1; cycle(); ack = 0;
    check("post_rst_save", 32'(exc_if.save_exc_cause_o), 1);
    idle_cycles(2);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      ill     = ($urandom_range(0, 15) == 0);
      ebr     = ($urandom_range(0, 15) == 0);
      ecl     = ($urandom_range(0, 15) == 0);
      tag     = ($urandom_range(0, 7) == 0);
      tag_src = 3'($urandom_range(0, 7));
      trap_en = ($urandom_range(0, 1) == 1);
      irq_en  = ($urandom_range(0, 3) != 0);
      ack     = ($urandom_range(0, 2) == 0);
      clr     = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 5) == 0) irq = $urandom() & $urandom() & $urandom();
      cycle();
    end
    irq = 0;
    idle_cycles(4);
    check("exp_q_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
